// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between committed stores (via an in-order store queue) and loads.
// Grants are combinational in the request cycle; load response returns one cycle after grant.
// st_ready drops when the queue is full; ld_ready is the load grant, loads wait while stores are forced.
module dmem_port_arbiter #(
  parameter int SQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int TAG_W        = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        st_valid,
  input  logic [31:0]                 st_addr,
  input  logic [2:0]                  st_funct3,
  input  logic [31:0]                 st_data,
  output logic                        st_ready,
  input  logic                        ld_valid,
  input  logic [31:0]                 ld_addr,
  input  logic [2:0]                  ld_funct3,
  input  logic [TAG_W-1:0]            ld_tag,
  output logic                        ld_ready,
  input  logic                        flush,
  output logic                        mem_we,
  output logic                        mem_re,
  output logic [31:0]                 mem_addr,
  output logic [2:0]                  mem_funct3,
  output logic [31:0]                 mem_wdata,
  input  logic [31:0]                 mem_rdata,
  output logic                        ld_resp_valid,
  output logic [TAG_W-1:0]            ld_resp_tag,
  output logic [31:0]                 ld_resp_data,
  output logic [$clog2(SQ_DEPTH):0]   sq_count,
  output logic                        idle
);

  localparam int PTR_W = $clog2(SQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // One spare value so the saturating counter can always hold STARVE_LIMIT.
  localparam int STV_W = $clog2(STARVE_LIMIT + 2);

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] data;
  } sq_entry_t;

  // Byte count of an access; unused encoding 11 treated as a word so overlap stays conservative.
  function automatic logic [2:0] acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  sq_entry_t          sq_mem_q [SQ_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic               resp_vld_q, resp_vld_d;
  logic [TAG_W-1:0]   resp_tag_q, resp_tag_d;

  logic               sq_nonempty, sq_full, starved, conflict;
  logic               grant_st, grant_ld, st_push;
  logic [32:0]        ld_beg, ld_end;
  sq_entry_t          head;

  assign head   = sq_mem_q[rd_ptr_q];
  assign ld_beg = {1'b0, ld_addr};
  assign ld_end = {1'b0, ld_addr} + {30'd0, acc_size(ld_funct3)};

  // Overlap check of the load against every occupied queue slot (33-bit ends avoid wrap).
  always_comb begin
    conflict = 1'b0;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      if (CNT_W'(k) < count_q) begin
        if (({1'b0, sq_mem_q[rd_ptr_q + PTR_W'(k)].addr} < ld_end) &&
            (ld_beg < {1'b0, sq_mem_q[rd_ptr_q + PTR_W'(k)].addr} +
                      {30'd0, acc_size(sq_mem_q[rd_ptr_q + PTR_W'(k)].funct3)})) begin
          conflict = 1'b1;
        end
      end
    end
  end

  // Single-grant arbitration and memory-port drive; all grants held off while reset is low.
  always_comb begin
    sq_nonempty = (count_q != '0);
    sq_full     = (count_q == CNT_W'(SQ_DEPTH));
    starved     = (starve_q == STV_W'(STARVE_LIMIT));
    grant_st    = reset & sq_nonempty & (~ld_valid | conflict | sq_full | starved);
    grant_ld    = reset & ld_valid & ~grant_st;
    st_ready    = reset & ~sq_full;
    st_push     = st_valid & st_ready & (st_funct3 inside {3'b000, 3'b001, 3'b010});
    ld_ready    = grant_ld;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_funct3  = '0;
    mem_wdata   = '0;
    if (grant_st) begin
      mem_we     = 1'b1;
      mem_addr   = head.addr;
      mem_funct3 = head.funct3;
      mem_wdata  = head.data;
    end else if (grant_ld) begin
      mem_re     = 1'b1;
      mem_addr   = ld_addr;
      mem_funct3 = ld_funct3;
    end
  end

  // Next-state for pointers, occupancy, starvation counter and the load response.
  always_comb begin
    wr_ptr_d   = st_push  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = grant_st ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({st_push, grant_st})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    starve_d   = starve_q;
    if (grant_st || !sq_nonempty) begin
      starve_d = '0;
    end else if (grant_ld && !starved) begin
      starve_d = starve_q + STV_W'(1);
    end
    resp_vld_d = grant_ld & ~flush;
    resp_tag_d = grant_ld ? ld_tag : resp_tag_q;
  end

  // Control state, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      resp_vld_q <= 1'b0;
      resp_tag_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      resp_vld_q <= resp_vld_d;
      resp_tag_q <= resp_tag_d;
    end
  end

  // Queue storage; contents are meaningless outside the occupied window so no reset needed.
  always_ff @(posedge clk) begin
    if (st_push) begin
      sq_mem_q[wr_ptr_q] <= '{addr: st_addr, funct3: st_funct3, data: st_data};
    end
  end

  assign ld_resp_valid = resp_vld_q;
  assign ld_resp_tag   = resp_tag_q;
  assign ld_resp_data  = mem_rdata;
  assign sq_count      = count_q;
  assign idle          = (count_q == '0) & ~resp_vld_q;

endmodule
